// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, the canonical NOP and the
// major opcodes also used by the control unit.
package rv32i_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC mux: sequential pc+4 or the control-selected target, plus a flag
// for targets that are not word aligned.
module next_pc_sel
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Select target or fall-through, then flag a misaligned result.
    always_comb begin
        next_pc = pc + 32'd4;
        if (pc_src) begin
            next_pc = pc_target;
        end else begin
            next_pc = pc + 32'd4;
        end
        misaligned = !word_aligned(next_pc[1:0]);
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues one outstanding imem request
// at a time and holds the returned word for decode until it is consumed.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op_code,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault
);

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] instr_r;
    logic            instr_valid_r;
    logic            req_valid_r;
    logic            fault_r;
    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;

    next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .pc        (pc_r),
        .pc_src    (pc_src),
        .pc_target (pc_target),
        .next_pc   (next_pc_s),
        .misaligned(misaligned_s)
    );

    // Fetch FSM; every visible control output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_RESET;
            pc_r          <= RESET_PC;
            instr_r       <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            req_valid_r   <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r     <= S_REQ;
                    req_valid_r <= 1'b1;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_r     <= S_WAIT;
                        req_valid_r <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_r       <= S_HOLD;
                        instr_r       <= imem_rdata;
                        instr_valid_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_valid_r && instr_ready) begin
                        pc_r          <= next_pc_s;
                        instr_valid_r <= 1'b0;
                        if (misaligned_s) begin
                            state_r <= S_FAULT;
                            fault_r <= 1'b1;
                        end else begin
                            state_r     <= S_REQ;
                            req_valid_r <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    req_valid_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fault_r       <= 1'b1;
                end
                // Corrupted encoding: park in the fault state rather than fetch.
                default: begin
                    state_r       <= S_FAULT;
                    req_valid_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fault_r       <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_addr      = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign pc             = pc_r;
    assign fetch_fault    = fault_r;
    assign op_code        = instr_r[6:0];
    assign func3          = instr_r[14:12];
    assign func7          = instr_r[31:25];
    assign pc_plus4       = pc_r + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// wrap/fall-through sequence, then randomized traffic against a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op_code;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LW   = 32'h0000_2083;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] ADD  = 32'h0020_81b3;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .op_code(op_code),
        .func3(func3), .func7(func7), .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .pc_target(pc_target), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // A response in the same cycle as the request is accepted is illegal.
    always @(posedge clk) begin
        if (rst_n === 1'b1)
            assert (!(imem_req_valid && imem_req_ready && imem_rsp_valid))
                else $error("response in the accept cycle");
    end

    typedef struct {
        logic        rst_n, rdy, rsp;
        logic [31:0] rdata;
        logic        iready, src;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic rdy, logic rsp, logic [31:0] rd,
                               logic ir, logic src, logic [31:0] tg, logic er,
                               logic [31:0] ea, logic eiv, logic [31:0] ei, logic ef);
        vec_t x;
        x.rst_n = r; x.rdy = rdy; x.rsp = rsp; x.rdata = rd; x.iready = ir;
        x.src = src; x.tgt = tg; x.e_req = er; x.e_addr = ea; x.e_iv = eiv;
        x.e_instr = ei; x.e_fault = ef;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rsp, input logic [31:0] rd,
                        input logic ir, input logic src, input logic [31:0] tg);
        @(negedge clk);
        rst_n = r; imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rdata = rd;
        instr_ready = ir; pc_src = src; pc_target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                           input logic eiv, input logic [31:0] ei, input logic ef);
        logic [31:0] e4;
        e4 = ea + 32'd4;
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, er});
        chk({tag, ".addr"}, imem_addr, ea);
        chk({tag, ".pc"}, pc, ea);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, eiv});
        chk({tag, ".instr"}, instr, ei);
        chk({tag, ".op_code"}, {25'd0, op_code}, {25'd0, ei[6:0]});
        chk({tag, ".func3"}, {29'd0, func3}, {29'd0, ei[14:12]});
        chk({tag, ".func7"}, {25'd0, func7}, {25'd0, ei[31:25]});
        chk({tag, ".pc_plus4"}, pc_plus4, e4);
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, ef});
    endtask

    // Reference model state for the random phase (transaction view).
    logic        m_live, m_req, m_pend, m_iv, m_fault;
    logic [31:0] m_pc, m_instr;

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rdata = 32'd0; instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'd0;

        tbl.push_back(v(1'b0,1'b0,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b1,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,LW,   1'b0,1'b0,32'd0, 1'b0,32'h0,1'b1,LW,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b1,1'b0,32'd0, 1'b1,32'h4,1'b0,LW,1'b0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b1,32'h4,1'b0,LW,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h4,1'b0,LW,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,ADDI, 1'b0,1'b0,32'd0, 1'b0,32'h4,1'b1,ADDI,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b1,1'b0,32'd0, 1'b1,32'h8,1'b0,ADDI,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h8,1'b0,ADDI,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,BEQ,  1'b0,1'b0,32'd0, 1'b0,32'h8,1'b1,BEQ,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b1,1'b1,32'h40, 1'b1,32'h40,1'b0,BEQ,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h40,1'b0,BEQ,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,ADD,  1'b0,1'b0,32'd0, 1'b0,32'h40,1'b1,ADD,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b0,1'b1,32'h42, 1'b0,32'h40,1'b1,ADD,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'd0,1'b1,1'b1,32'h42, 1'b0,32'h42,1'b0,ADD,1'b1));
        tbl.push_back(v(1'b1,1'b1,1'b1,DEAD, 1'b0,1'b0,32'd0, 1'b0,32'h42,1'b0,ADD,1'b1));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b1,1'b0,32'd0, 1'b0,32'h42,1'b0,ADD,1'b1));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b1,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,DEAD, 1'b0,1'b0,32'd0, 1'b1,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,DEAD, 1'b0,1'b0,32'd0, 1'b1,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b0,NOP,1'b0));
        tbl.push_back(v(1'b1,1'b0,1'b1,32'h33,1'b0,1'b0,32'd0, 1'b0,32'h0,1'b1,32'h33,1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].rdy, tbl[i].rsp, tbl[i].rdata,
                 tbl[i].iready, tbl[i].src, tbl[i].tgt);
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_iv, tbl[i].e_instr, tbl[i].e_fault);
            if (i == 3) begin
                chk("lw.op_code", {25'd0, op_code}, 32'h0000_0003);
                chk("lw.pc_plus4", pc_plus4, 32'h0000_0004);
            end
        end

        // Jump to the top word, fetch it, then fall through and wrap to 0.
        step(1'b1,1'b0,1'b0,32'd0,1'b1,1'b1,32'hFFFF_FFFC);
        chk_all("wrap.req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h33, 1'b0);
        step(1'b1,1'b1,1'b0,32'd0,1'b0,1'b0,32'd0);
        step(1'b1,1'b0,1'b1,BEQ,1'b0,1'b0,32'd0);
        chk_all("wrap.hold", 1'b0, 32'hFFFF_FFFC, 1'b1, BEQ, 1'b0);
        chk("wrap.pc_plus4", pc_plus4, 32'h0000_0000);
        step(1'b1,1'b0,1'b0,32'd0,1'b1,1'b0,32'h40);
        chk_all("fallthru.req", 1'b1, 32'h0000_0000, 1'b0, BEQ, 1'b0);

        // Randomized phase: start from a clean reset.
        step(1'b0,1'b0,1'b0,32'd0,1'b0,1'b0,32'd0);
        m_live = 1'b0; m_req = 1'b0; m_pend = 1'b0; m_iv = 1'b0; m_fault = 1'b0;
        m_pc = 32'd0; m_instr = NOP;
        for (int c = 0; c < 3000; c++) begin
            logic        r, rdy, rsp, ir, src;
            logic [31:0] rd, tg, nxt;
            int          sel;
            r   = ($urandom_range(0, 59) != 0);
            rdy = $urandom_range(0, 2) != 0;
            rsp = $urandom_range(0, 2) != 0;
            if (m_req && rdy) rsp = 1'b0;
            rd  = $urandom;
            ir  = $urandom_range(0, 2) != 0;
            src = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 15);
            if (sel == 0)      tg = 32'hFFFF_FFFC;
            else if (sel == 1) tg = {$urandom_range(0, 1023), 2'b00} + 32'd1 + 32'($urandom_range(0, 2));
            else               tg = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};

            if (!r) begin
                m_live = 1'b0; m_req = 1'b0; m_pend = 1'b0; m_iv = 1'b0;
                m_fault = 1'b0; m_pc = 32'd0; m_instr = NOP;
            end else if (!m_live) begin
                m_live = 1'b1; m_req = 1'b1;
            end else if (m_fault) begin
                m_req = 1'b0;
            end else if (m_req) begin
                if (rdy) begin m_req = 1'b0; m_pend = 1'b1; end
            end else if (m_pend) begin
                if (rsp) begin m_pend = 1'b0; m_iv = 1'b1; m_instr = rd; end
            end else if (m_iv && ir) begin
                nxt  = src ? tg : m_pc + 32'd4;
                m_pc = nxt;
                m_iv = 1'b0;
                if (nxt % 4 != 0) m_fault = 1'b1;
                else              m_req = 1'b1;
            end

            step(r, rdy, rsp, rd, ir, src, tg);
            chk("rnd.req_valid", {31'd0, imem_req_valid}, {31'd0, m_req});
            chk("rnd.addr", imem_addr, m_pc);
            chk("rnd.instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
            chk("rnd.instr", instr, m_instr);
            chk("rnd.pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("rnd.fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
